// File: rtl/svm_linear_mac_if.sv
// Handshake and configuration bundle for the linear-SVM scoring engine.
// The master side feeds windows and weights; the slave side is the engine.
interface svm_linear_mac_if #(
    parameter int N_FEAT = 4,
    parameter int DW     = 32,
    parameter int WW     = 16,
    parameter int ACC_W  = 48
);
    localparam int AW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    logic                   start;
    logic [N_FEAT*DW-1:0]   features;
    logic                   w_we;
    logic [AW-1:0]          w_addr;
    logic [WW-1:0]          w_data;
    logic                   b_we;
    logic [ACC_W-1:0]       b_data;
    logic                   busy;
    logic                   done;
    logic [ACC_W-1:0]       score;
    logic                   raw_positive;
    logic                   fall_detected;
    logic                   cfg_err;

    modport master (
        output start, features, w_we, w_addr, w_data, b_we, b_data,
        input  busy, done, score, raw_positive, fall_detected, cfg_err
    );

    modport slave (
        input  start, features, w_we, w_addr, w_data, b_we, b_data,
        output busy, done, score, raw_positive, fall_detected, cfg_err
    );
endinterface

// File: rtl/svm_linear_mac.sv
// Linear-SVM fall classifier: bias + sum(x_i*w_i), one MAC per cycle,
// with saturating accumulation and a consecutive-positive confirm filter.
module svm_linear_mac #(
    parameter int N_FEAT  = 4,
    parameter int DW      = 32,
    parameter int FRAC    = 16,
    parameter int WW      = 16,
    parameter int WFRAC   = 12,
    parameter int ACC_W   = 48,
    parameter int CONFIRM = 3
) (
    input  logic clk,
    input  logic reset,
    svm_linear_mac_if.slave bus
);
    localparam int AW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int PW = DW + WW;
    localparam int CW = $clog2(CONFIRM + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MAC    = 2'd1;
    localparam logic [1:0] S_DECIDE = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Catch illegal parameterisations at elaboration time.
    if (N_FEAT < 1 || CONFIRM < 1) begin : g_bad_count
        $error("svm_linear_mac: N_FEAT and CONFIRM must be >= 1");
    end
    if (ACC_W < PW) begin : g_bad_acc
        $error("svm_linear_mac: ACC_W must be >= DW+WW");
    end
    if (FRAC > DW || WFRAC > WW) begin : g_bad_frac
        $error("svm_linear_mac: fractional bits exceed word width");
    end

    logic [1:0]        state;
    logic [AW-1:0]     idx;
    logic [DW-1:0]     x     [N_FEAT];
    logic [WW-1:0]     w     [N_FEAT];
    logic [WW-1:0]     w_win [N_FEAT];
    logic [ACC_W-1:0]  bias;
    logic [ACC_W-1:0]  acc;
    logic [CW-1:0]     cnt;

    logic              idle;
    logic              accept;
    logic              cfg_try;
    logic              last;
    logic              addr_ok;
    logic              acc_pos;

    logic [PW-1:0]     xa;
    logic [PW-1:0]     wa;
    logic [PW-1:0]     prod;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  acc_next;

    assign idle     = (state == S_IDLE);
    assign accept   = idle && bus.start;
    assign cfg_try  = bus.w_we || bus.b_we;
    assign last     = (idx == AW'(N_FEAT - 1));
    assign addr_ok  = ({1'b0, bus.w_addr} < (AW+1)'(N_FEAT));
    assign acc_pos  = !acc[ACC_W-1] && (acc != '0);
    assign bus.busy = !idle;

    // Full-precision signed product and one saturating accumulate step.
    always_comb begin
        xa   = {{WW{x[idx][DW-1]}}, x[idx]};
        wa   = {{DW{w_win[idx][WW-1]}}, w_win[idx]};
        prod = xa * wa;
        sum  = {acc[ACC_W-1], acc}
             + {{(ACC_W+1-PW){prod[PW-1]}}, prod};
        acc_next = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Sequencer: IDLE -> MAC (N_FEAT cycles) -> DECIDE -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (bus.start) begin
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    idx <= idx + 1'b1;
                    if (last) begin
                        idx   <= '0;
                        state <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Window operands: features and a weight snapshot taken on start,
    // so later weight writes cannot reach a window in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N_FEAT; i++) begin
                x[i]     <= bus.features[i*DW +: DW];
                w_win[i] <= w[i];
            end
        end
    end

    // Accumulator: seeded with bias on start, one MAC per MAC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (accept) begin
            acc <= bias;
        end else if (state == S_MAC) begin
            acc <= acc_next;
        end
    end

    // Runtime weight/bias registers, writable only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_FEAT; i++) begin
                w[i] <= '0;
            end
            bias <= '0;
        end else if (idle) begin
            if (bus.w_we && addr_ok) begin
                w[bus.w_addr] <= bus.w_data;
            end
            if (bus.b_we) begin
                bias <= bus.b_data;
            end
        end
    end

    // Flag configuration attempts that were dropped because a window ran.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cfg_err <= 1'b0;
        end else begin
            bus.cfg_err <= !idle && cfg_try;
        end
    end

    // Result publication and consecutive-positive confirmation.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.done          <= 1'b0;
            bus.score         <= '0;
            bus.raw_positive  <= 1'b0;
            bus.fall_detected <= 1'b0;
            cnt               <= '0;
        end else begin
            bus.done <= 1'b0;
            if (state == S_DECIDE) begin
                bus.done         <= 1'b1;
                bus.score        <= acc;
                bus.raw_positive <= acc_pos;
                if (acc_pos) begin
                    if (cnt != CW'(CONFIRM)) begin
                        cnt <= cnt + 1'b1;
                    end
                    bus.fall_detected <= (32'(cnt) + 1 >= CONFIRM);
                end else begin
                    cnt               <= '0;
                    bus.fall_detected <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_svm_linear_mac.sv
// Directed bench for svm_linear_mac: vector table of weight/bias/feature
// sets with hand-computed scores, plus timing, confirm and reset sequences.
module tb_svm_linear_mac;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WW = 16;
    localparam int AW = 48;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    svm_linear_mac_if #(.N_FEAT(N), .DW(DW), .WW(WW), .ACC_W(AW)) bus ();

    svm_linear_mac #(
        .N_FEAT(N), .DW(DW), .FRAC(16), .WW(WW),
        .WFRAC(12), .ACC_W(AW), .CONFIRM(3)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string         name;
        logic [127:0]  feats;
        logic [63:0]   ws;
        logic [47:0]   bias;
        logic [47:0]   exp_score;
        logic          exp_pos;
    } vec_t;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic write_cfg(input logic we, input logic [1:0] addr,
                             input logic [15:0] data, input logic bwe,
                             input logic [47:0] bdata);
        @(negedge clk);
        bus.w_we   = we;
        bus.w_addr = addr;
        bus.w_data = data;
        bus.b_we   = bwe;
        bus.b_data = bdata;
        @(negedge clk);
        bus.w_we = 1'b0;
        bus.b_we = 1'b0;
    endtask

    task automatic load_cfg(input logic [63:0] ws, input logic [47:0] b);
        for (int i = 0; i < N - 1; i++) begin
            write_cfg(1'b1, 2'(i), ws[i*16 +: 16], 1'b0, '0);
        end
        write_cfg(1'b1, 2'd3, ws[48 +: 16], 1'b1, b);
    endtask

    task automatic run_window(input logic [127:0] f, output int lat);
        @(negedge clk);
        bus.features = f;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vecs [7];
    int   lat;
    int   dcnt;
    int   done_at [$];
    logic [127:0] f_one;

    initial begin
        vecs[0] = '{"unit", {96'd0, 32'h0001_0000},
                    {48'd0, 16'h1000}, 48'd0, 48'h0000_1000_0000, 1'b1};
        vecs[1] = '{"neg_bias", {96'd0, 32'h0001_0000},
                    {48'd0, 16'h1000}, -48'sh2000_0000,
                    48'hFFFF_F000_0000, 1'b0};
        vecs[2] = '{"sat_pos", {4{32'h7FFF_FFFF}}, {4{16'h7FFF}},
                    48'd0, 48'h7FFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{"sat_neg", {4{32'h8000_0000}}, {4{16'h7FFF}},
                    48'd0, 48'h8000_0000_0000, 1'b0};
        vecs[4] = '{"zero", 128'd0, 64'd0, 48'd0, 48'd0, 1'b0};
        vecs[5] = '{"mixed",
                    {32'h0003_0000, 32'h0000_8000,
                     32'hFFFE_0000, 32'h0001_0000},
                    {16'h0400, 16'hF000, 16'h0800, 16'h1000},
                    48'h1000, 48'h0000_0400_1000, 1'b1};
        vecs[6] = '{"sticky", {32'd0, 32'h8000_0000,
                    32'h7FFF_FFFF, 32'h7FFF_FFFF}, {4{16'h7FFF}},
                    48'h7FFF_FFFF_FFFF, 48'h4000_7FFF_FFFF, 1'b1};

        f_one        = {96'd0, 32'h0001_0000};
        bus.start    = 1'b0;
        bus.features = '0;
        bus.w_we     = 1'b0;
        bus.w_addr   = '0;
        bus.w_data   = '0;
        bus.b_we     = 1'b0;
        bus.b_data   = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_score", 64'(bus.score), 64'd0);
        chk("rst_raw", 64'(bus.raw_positive), 64'd0);
        chk("rst_fall", 64'(bus.fall_detected), 64'd0);
        chk("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
        reset = 1'b0;

        // Confirm filter: fall only on the third positive done.
        load_cfg({48'd0, 16'h1000}, 48'd0);
        for (int k = 1; k <= 3; k++) begin
            run_window(f_one, lat);
            chk($sformatf("conf%0d_lat", k), 64'(lat), 64'd6);
            chk($sformatf("conf%0d_score", k), 64'(bus.score),
                64'h1000_0000);
            chk($sformatf("conf%0d_fall", k), 64'(bus.fall_detected),
                (k == 3) ? 64'd1 : 64'd0);
        end

        // A negative window clears the filter; next positive stays low.
        write_cfg(1'b0, 2'd0, '0, 1'b1, -48'sh2000_0000);
        run_window(f_one, lat);
        chk("neg_score", 64'(bus.score), 64'h0000_FFFF_F000_0000);
        chk("neg_raw", 64'(bus.raw_positive), 64'd0);
        chk("neg_fall", 64'(bus.fall_detected), 64'd0);
        write_cfg(1'b0, 2'd0, '0, 1'b1, 48'd0);
        run_window(f_one, lat);
        chk("repos_fall", 64'(bus.fall_detected), 64'd0);

        // Table of scoring vectors.
        for (int v = 0; v < 7; v++) begin
            load_cfg(vecs[v].ws, vecs[v].bias);
            run_window(vecs[v].feats, lat);
            chk({vecs[v].name, "_lat"}, 64'(lat), 64'd6);
            chk({vecs[v].name, "_score"}, 64'(bus.score),
                64'(vecs[v].exp_score));
            chk({vecs[v].name, "_raw"}, 64'(bus.raw_positive),
                64'(vecs[v].exp_pos));
        end

        // Ignored starts while busy; a start coincident with done is taken.
        load_cfg({48'd0, 16'h1000}, 48'd0);
        bus.features = f_one;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (bus.done) done_at.push_back(k);
            if (k == 1) chk("t4_busy", 64'(bus.busy), 64'd1);
            bus.start = (k == 0 || k == 2 || k == 4 || bus.done);
        end
        bus.start = 1'b0;
        chk("t4_ndone", 64'(done_at.size()), 64'd2);
        if (done_at.size() == 2) begin
            chk("t4_done1", 64'(done_at[0]), 64'd6);
            chk("t4_done2", 64'(done_at[1]), 64'd12);
        end
        repeat (8) @(negedge clk);

        // Weight write while busy is dropped and flagged.
        load_cfg({48'd0, 16'h1000}, 48'd0);
        @(negedge clk);
        bus.features = {64'd0, 32'h0001_0000, 32'h0001_0000};
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.w_we   = 1'b1;
        bus.w_addr = 2'd1;
        bus.w_data = 16'h1000;
        @(negedge clk);
        bus.w_we = 1'b0;
        chk("busy_cfg_err", 64'(bus.cfg_err), 64'd1);
        dcnt = 0;
        while (!bus.done && dcnt < 20) begin
            @(negedge clk);
            dcnt++;
        end
        chk("busy_wr_done", 64'(bus.done), 64'd1);
        chk("busy_wr_score", 64'(bus.score), 64'h1000_0000);
        write_cfg(1'b1, 2'd1, 16'h1000, 1'b0, '0);
        chk("idle_cfg_err", 64'(bus.cfg_err), 64'd0);
        run_window({64'd0, 32'h0001_0000, 32'h0001_0000}, lat);
        chk("idle_wr_score", 64'(bus.score), 64'h2000_0000);

        // Reset mid-MAC aborts the window and clears everything.
        load_cfg({4{16'h1000}}, 48'd0);
        for (int k = 0; k < 3; k++) run_window(f_one, lat);
        chk("pre_rst_fall", 64'(bus.fall_detected), 64'd1);
        @(negedge clk);
        bus.features = f_one;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_fall", 64'(bus.fall_detected), 64'd0);
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("mid_rst_nodone", 64'(dcnt), 64'd0);
        run_window(f_one, lat);
        chk("post_rst_score", 64'(bus.score), 64'd0);
        chk("post_rst_raw", 64'(bus.raw_positive), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
